// File: rtl/jtag_dtm_oversampled_pkg.sv
// Shared definitions for the oversampled JTAG DTM: TAP states, IR codes,
// DMI op and status codes, and the IEEE 1149.1 next-state function.
package jtag_defs;

    typedef enum logic [3:0] {
        TAP_EXIT2_DR   = 4'h0,
        TAP_EXIT1_DR   = 4'h1,
        TAP_SHIFT_DR   = 4'h2,
        TAP_PAUSE_DR   = 4'h3,
        TAP_SELECT_IR  = 4'h4,
        TAP_UPDATE_DR  = 4'h5,
        TAP_CAPTURE_DR = 4'h6,
        TAP_SELECT_DR  = 4'h7,
        TAP_EXIT2_IR   = 4'h8,
        TAP_EXIT1_IR   = 4'h9,
        TAP_SHIFT_IR   = 4'hA,
        TAP_PAUSE_IR   = 4'hB,
        TAP_RUN_IDLE   = 4'hC,
        TAP_UPDATE_IR  = 4'hD,
        TAP_CAPTURE_IR = 4'hE,
        TAP_RESET      = 4'hF
    } tap_state_e;

    localparam logic [4:0] IR_IDCODE = 5'h01;
    localparam logic [4:0] IR_DTMCS  = 5'h10;
    localparam logic [4:0] IR_DMI    = 5'h11;
    localparam logic [4:0] IR_BYPASS = 5'h1f;

    localparam logic [1:0] DMI_OP_NOP   = 2'd0;
    localparam logic [1:0] DMI_OP_READ  = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE = 2'd2;

    localparam logic [1:0] DMISTAT_OK     = 2'd0;
    localparam logic [1:0] DMISTAT_FAILED = 2'd2;
    localparam logic [1:0] DMISTAT_BUSY   = 2'd3;

    function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
        tap_state_e n;
        case (s)
            TAP_RESET:      n = tms ? TAP_RESET     : TAP_RUN_IDLE;
            TAP_RUN_IDLE:   n = tms ? TAP_SELECT_DR : TAP_RUN_IDLE;
            TAP_SELECT_DR:  n = tms ? TAP_SELECT_IR : TAP_CAPTURE_DR;
            TAP_CAPTURE_DR: n = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_SHIFT_DR:   n = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_EXIT1_DR:   n = tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR:   n = tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
            TAP_EXIT2_DR:   n = tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
            TAP_UPDATE_DR:  n = tms ? TAP_SELECT_DR : TAP_RUN_IDLE;
            TAP_SELECT_IR:  n = tms ? TAP_RESET     : TAP_CAPTURE_IR;
            TAP_CAPTURE_IR: n = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_SHIFT_IR:   n = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_EXIT1_IR:   n = tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR:   n = tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
            TAP_EXIT2_IR:   n = tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
            TAP_UPDATE_IR:  n = tms ? TAP_SELECT_DR : TAP_RUN_IDLE;
            default:        n = TAP_RESET;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_dtm_oversampled_edge_sync.sv
// Synchronises tck/tms/tdi into clk and flags tck edges; tms and tdi go
// through the same depth so they line up with the detected edge.
module jtag_edge_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tck_i,
    input  logic tms_i,
    input  logic tdi_i,
    output logic tck_rise_o,
    output logic tck_fall_o,
    output logic tms_o,
    output logic tdi_o
);

    logic [STAGES-1:0] tck_q;
    logic [STAGES-1:0] tms_q;
    logic [STAGES-1:0] tdi_q;
    logic              tck_prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tck_q      <= '0;
            tms_q      <= '0;
            tdi_q      <= '0;
            tck_prev_q <= 1'b0;
        end else begin
            tck_q      <= {tck_q[STAGES-2:0], tck_i};
            tms_q      <= {tms_q[STAGES-2:0], tms_i};
            tdi_q      <= {tdi_q[STAGES-2:0], tdi_i};
            tck_prev_q <= tck_q[STAGES-1];
        end
    end

    assign tck_rise_o = tck_q[STAGES-1] & ~tck_prev_q;
    assign tck_fall_o = ~tck_q[STAGES-1] & tck_prev_q;
    assign tms_o      = tms_q[STAGES-1];
    assign tdi_o      = tdi_q[STAGES-1];

endmodule

// File: rtl/jtag_dtm_oversampled.sv
// RISC-V JTAG DTM running in the system clock domain: oversampled TAP,
// IDCODE/DTMCS/DMI/BYPASS registers and a valid/ready DMI bridge to the DM.
module jtag_dtm_oversampled
    import jtag_defs::*;
#(
    parameter logic [31:0] IDCODE_VAL  = 32'h1e200a6d,
    parameter int unsigned ABITS       = 6,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jtag_tck,
    input  logic             jtag_tms,
    input  logic             jtag_tdi,
    output logic             jtag_tdo,
    output logic             dm_req_valid,
    input  logic             dm_req_ready,
    output logic [ABITS-1:0] dm_req_addr,
    output logic [31:0]      dm_req_data,
    output logic [1:0]       dm_req_op,
    input  logic             dm_resp_valid,
    input  logic [31:0]      dm_resp_data
);

    localparam int unsigned DR_W        = ABITS + 34;
    localparam int unsigned PAD_W       = DR_W - 32;
    localparam logic [5:0]  ABITS_FIELD = 6'(ABITS);

    logic tck_rise, tck_fall, tms_s, tdi_s;

    tap_state_e state_q;

    logic [4:0]       ir_q, ir_d, ir_sr_q, ir_sr_d;
    logic [DR_W-1:0]  dr_sr_q, dr_sr_d, dr_capture, dr_shifted;
    logic             tdo_q, tdo_d;
    logic             req_valid_q, req_valid_d;
    logic [ABITS-1:0] req_addr_q, req_addr_d, last_addr_q, last_addr_d;
    logic [31:0]      req_data_q, req_data_d, resp_data_q, resp_data_d;
    logic [1:0]       req_op_q, req_op_d, dmistat_q, dmistat_d;
    logic             busy_q, busy_d;
    logic [31:0]      dtmcs;
    logic [1:0]       upd_op;

    jtag_edge_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk_i      (clk),
        .rst_i      (rst),
        .tck_i      (jtag_tck),
        .tms_i      (jtag_tms),
        .tdi_i      (jtag_tdi),
        .tck_rise_o (tck_rise),
        .tck_fall_o (tck_fall),
        .tms_o      (tms_s),
        .tdi_o      (tdi_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TAP_RESET;
        end else if (tck_rise) begin
            state_q <= tap_next(state_q, tms_s);
        end
    end

    assign dtmcs  = {14'b0, 1'b0, 1'b0, 1'b0, 3'd1, dmistat_q, ABITS_FIELD, 4'd1};
    assign upd_op = dr_sr_q[1:0];

    // tdi enters at the top of whichever register length the IR selects
    always_comb begin
        dr_shifted = dr_sr_q >> 1;
        case (ir_q)
            IR_IDCODE, IR_DTMCS: dr_shifted[31]     = tdi_s;
            IR_DMI:              dr_shifted[DR_W-1] = tdi_s;
            default:             dr_shifted[0]      = tdi_s;
        endcase
    end

    always_comb begin
        ir_d        = ir_q;
        ir_sr_d     = ir_sr_q;
        dr_sr_d     = dr_sr_q;
        tdo_d       = tdo_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        req_op_d    = req_op_q;
        last_addr_d = last_addr_q;
        resp_data_d = resp_data_q;
        dmistat_d   = dmistat_q;
        busy_d      = busy_q;
        dr_capture  = '0;

        if (req_valid_q && dm_req_ready) begin
            req_valid_d = 1'b0;
        end
        if (dm_resp_valid && busy_q) begin
            busy_d = 1'b0;
            if (req_op_q == DMI_OP_READ) begin
                resp_data_d = dm_resp_data;
            end
        end

        // Capture sees a response landing this same cycle
        case (ir_q)
            IR_IDCODE: dr_capture = {{PAD_W{1'b0}}, IDCODE_VAL};
            IR_DTMCS:  dr_capture = {{PAD_W{1'b0}}, dtmcs};
            IR_DMI:    dr_capture = {last_addr_q, resp_data_d, dmistat_q};
            default:   dr_capture = '0;
        endcase

        if (state_q == TAP_RESET) begin
            ir_d = IR_IDCODE;
        end

        if (tck_rise) begin
            case (state_q)
                TAP_CAPTURE_IR: ir_sr_d = 5'b00001;
                TAP_SHIFT_IR:   ir_sr_d = {tdi_s, ir_sr_q[4:1]};
                TAP_CAPTURE_DR: dr_sr_d = dr_capture;
                TAP_SHIFT_DR:   dr_sr_d = dr_shifted;
                default: ;
            endcase
        end

        if (tck_fall) begin
            case (state_q)
                TAP_SHIFT_IR:  tdo_d = ir_sr_q[0];
                TAP_SHIFT_DR:  tdo_d = dr_sr_q[0];
                TAP_UPDATE_IR: ir_d  = ir_sr_q;
                TAP_UPDATE_DR: begin
                    if (ir_q == IR_DMI &&
                        (upd_op == DMI_OP_READ || upd_op == DMI_OP_WRITE) &&
                        dmistat_q == DMISTAT_OK) begin
                        if (busy_d) begin
                            dmistat_d = DMISTAT_BUSY;
                        end else begin
                            req_valid_d = 1'b1;
                            busy_d      = 1'b1;
                            req_op_d    = upd_op;
                            req_data_d  = dr_sr_q[33:2];
                            req_addr_d  = dr_sr_q[DR_W-1:34];
                            last_addr_d = dr_sr_q[DR_W-1:34];
                        end
                    end
                    if (ir_q == IR_DTMCS) begin
                        if (dr_sr_q[16]) begin
                            dmistat_d = DMISTAT_OK;
                        end
                        if (dr_sr_q[17]) begin
                            dmistat_d   = DMISTAT_OK;
                            busy_d      = 1'b0;
                            req_valid_d = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q        <= IR_IDCODE;
            ir_sr_q     <= '0;
            dr_sr_q     <= '0;
            tdo_q       <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_op_q    <= '0;
            last_addr_q <= '0;
            resp_data_q <= '0;
            dmistat_q   <= DMISTAT_OK;
            busy_q      <= 1'b0;
        end else begin
            ir_q        <= ir_d;
            ir_sr_q     <= ir_sr_d;
            dr_sr_q     <= dr_sr_d;
            tdo_q       <= tdo_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            req_op_q    <= req_op_d;
            last_addr_q <= last_addr_d;
            resp_data_q <= resp_data_d;
            dmistat_q   <= dmistat_d;
            busy_q      <= busy_d;
        end
    end

    assign jtag_tdo     = tdo_q;
    assign dm_req_valid = req_valid_q;
    assign dm_req_addr  = req_addr_q;
    assign dm_req_data  = req_data_q;
    assign dm_req_op    = req_op_q;

endmodule

// File: tb/tb_jtag_dtm_oversampled.sv
// Scoreboard bench for jtag_dtm_oversampled: a host bit-bangs TCK/TMS/TDI,
// a DM model answers requests, and a monitor checks scans, requests and pins.
module tb_jtag_dtm_oversampled;

    localparam int unsigned ABITS = 6;
    localparam logic [31:0] IDC   = 32'h1e200a6d;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             jtag_tck = 1'b0;
    logic             jtag_tms = 1'b1;
    logic             jtag_tdi = 1'b0;
    logic             jtag_tdo;
    logic             dm_req_valid;
    logic             dm_req_ready = 1'b1;
    logic [ABITS-1:0] dm_req_addr;
    logic [31:0]      dm_req_data;
    logic [1:0]       dm_req_op;
    logic             dm_resp_valid = 1'b0;
    logic [31:0]      dm_resp_data = '0;

    always #5 clk = ~clk;

    jtag_dtm_oversampled #(
        .IDCODE_VAL  (IDC),
        .ABITS       (ABITS),
        .SYNC_STAGES (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .jtag_tck      (jtag_tck),
        .jtag_tms      (jtag_tms),
        .jtag_tdi      (jtag_tdi),
        .jtag_tdo      (jtag_tdo),
        .dm_req_valid  (dm_req_valid),
        .dm_req_ready  (dm_req_ready),
        .dm_req_addr   (dm_req_addr),
        .dm_req_data   (dm_req_data),
        .dm_req_op     (dm_req_op),
        .dm_resp_valid (dm_resp_valid),
        .dm_resp_data  (dm_resp_data)
    );

    typedef struct { string name; logic [39:0] val; } scan_t;
    typedef struct { logic [5:0] addr; logic [31:0] data; logic [1:0] op; } req_t;
    typedef struct { string name; logic v; logic t; } pin_t;

    scan_t       exp_scan[$];
    logic [39:0] obs_scan[$];
    req_t        exp_req[$];
    pin_t        pin_q[$];

    int vectors     = 0;
    int miscompares = 0;
    bit final_req   = 1'b0;
    bit final_done  = 1'b0;
    int inject_req  = 0;

    // DM model: answers 2 cycles after acceptance; writes return junk data
    initial begin
        int    resp_cnt;
        int    inject_done;
        logic [31:0] resp_pend;
        resp_cnt    = 0;
        inject_done = 0;
        resp_pend   = '0;
        forever begin
            @(negedge clk);
            dm_resp_valid = 1'b0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    dm_resp_valid = 1'b1;
                    dm_resp_data  = resp_pend;
                end
            end
            if (dm_req_valid && dm_req_ready) begin
                resp_cnt  = 2;
                resp_pend = (dm_req_op == 2'd1) ?
                            ((dm_req_addr == 6'h11) ? 32'h00000c82 : 32'h0) : 32'hbad0bad0;
            end
            if (inject_req != inject_done) begin
                inject_done++;
                dm_resp_valid = 1'b1;
                dm_resp_data  = 32'hffffffff;
            end
        end
    end

    initial begin
        bit drop_pending;
        drop_pending = 1'b0;
        forever begin
            @(negedge clk);
            if (drop_pending) begin
                drop_pending = 1'b0;
                vectors++;
                if (dm_req_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL req_drop: valid got %b expected 0", dm_req_valid);
                end
            end
            if (dm_req_valid && dm_req_ready) begin
                vectors++;
                drop_pending = 1'b1;
                if (exp_req.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_req: got addr %h data %h op %0d expected none",
                             dm_req_addr, dm_req_data, dm_req_op);
                end else begin
                    req_t e;
                    e = exp_req.pop_front();
                    if (dm_req_addr !== e.addr || dm_req_data !== e.data || dm_req_op !== e.op) begin
                        miscompares++;
                        $display("FAIL dm_req: got addr %h data %h op %0d expected addr %h data %h op %0d",
                                 dm_req_addr, dm_req_data, dm_req_op, e.addr, e.data, e.op);
                    end
                end
            end
            while (obs_scan.size() > 0) begin
                logic [39:0] o;
                o = obs_scan.pop_front();
                vectors++;
                if (exp_scan.size() == 0) begin
                    miscompares++;
                    $display("FAIL scan_unexpected: got %h expected nothing", o);
                end else begin
                    scan_t e;
                    e = exp_scan.pop_front();
                    if (o !== e.val) begin
                        miscompares++;
                        $display("FAIL %s: got %h expected %h", e.name, o, e.val);
                    end
                end
            end
            while (pin_q.size() > 0) begin
                pin_t p;
                p = pin_q.pop_front();
                vectors++;
                if (dm_req_valid !== p.v || jtag_tdo !== p.t) begin
                    miscompares++;
                    $display("FAIL %s: got valid %b tdo %b expected valid %b tdo %b",
                             p.name, dm_req_valid, jtag_tdo, p.v, p.t);
                end
            end
            if (final_req && !final_done) begin
                vectors++;
                if (exp_scan.size() != 0 || exp_req.size() != 0) begin
                    miscompares++;
                    $display("FAIL leftover: got %0d scans %0d reqs pending expected 0 0",
                             exp_scan.size(), exp_req.size());
                end
                final_done = 1'b1;
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tclk(input logic m, input logic d, output logic o);
        jtag_tms = m;
        jtag_tdi = d;
        #80;
        o = jtag_tdo;
        jtag_tck = 1'b1;
        #80;
        jtag_tck = 1'b0;
    endtask

    task automatic scan_ir(input logic [4:0] v);
        logic o;
        logic [4:0] out;
        out = '0;
        tclk(1'b1, 1'b0, o);
        tclk(1'b1, 1'b0, o);
        tclk(1'b0, 1'b0, o);
        tclk(1'b0, 1'b0, o);
        for (int i = 0; i < 5; i++) tclk(i == 4, v[i], out[i]);
        tclk(1'b1, 1'b0, o);
        tclk(1'b0, 1'b0, o);
        obs_scan.push_back({35'b0, out});
    endtask

    task automatic scan_dr(input int len, input logic [39:0] v);
        logic o;
        logic [39:0] out;
        out = '0;
        tclk(1'b1, 1'b0, o);
        tclk(1'b0, 1'b0, o);
        tclk(1'b0, 1'b0, o);
        for (int i = 0; i < len; i++) tclk(i == len - 1, v[i], out[i]);
        tclk(1'b1, 1'b0, o);
        tclk(1'b0, 1'b0, o);
        obs_scan.push_back(out);
    endtask

    task automatic expect_scan(input string n, input logic [39:0] v);
        scan_t s;
        s.name = n;
        s.val  = v;
        exp_scan.push_back(s);
    endtask

    task automatic expect_req(input logic [5:0] a, input logic [31:0] d, input logic [1:0] op);
        req_t r;
        r.addr = a;
        r.data = d;
        r.op   = op;
        exp_req.push_back(r);
    endtask

    task automatic expect_pins(input string n, input logic v, input logic t);
        pin_t p;
        p.name = n;
        p.v    = v;
        p.t    = t;
        pin_q.push_back(p);
    endtask

    initial begin
        logic o;
        repeat (5) @(negedge clk);
        expect_pins("reset_outputs", 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) tclk(1'b1, 1'b0, o);
        tclk(1'b0, 1'b0, o);
        expect_scan("idcode", {8'h0, IDC});
        scan_dr(32, '0);

        expect_scan("ir_out_dmi", 40'h1);
        scan_ir(5'h11);

        expect_scan("dmi_wr_cap", 40'h0);
        expect_req(6'h10, 32'h1, 2'd2);
        scan_dr(40, {6'h10, 32'h00000001, 2'b10});
        repeat (20) @(negedge clk);

        expect_scan("dmi_rd_cap", {6'h10, 32'h0, 2'b00});
        expect_req(6'h11, 32'h0, 2'd1);
        scan_dr(40, {6'h11, 32'h0, 2'b01});
        repeat (20) @(negedge clk);

        expect_scan("dmi_rd_data", {6'h11, 32'h00000c82, 2'b00});
        scan_dr(40, '0);

        // Held-off request, then an overlapping update that must be refused
        dm_req_ready = 1'b0;
        expect_scan("dmi_wr1_cap", {6'h11, 32'h00000c82, 2'b00});
        expect_req(6'h05, 32'hdeadbeef, 2'd2);
        scan_dr(40, {6'h05, 32'hdeadbeef, 2'b10});
        expect_scan("dmi_wr2_cap", {6'h05, 32'h00000c82, 2'b00});
        scan_dr(40, {6'h06, 32'h12345678, 2'b10});
        expect_scan("dmistat_busy", {6'h05, 32'h00000c82, 2'b11});
        scan_dr(40, '0);
        expect_scan("ir_out_dtmcs", 40'h1);
        scan_ir(5'h10);
        expect_scan("dtmcs_busy", 40'h1c61);
        scan_dr(32, 40'h10000);
        expect_scan("dtmcs_cleared", 40'h1061);
        scan_dr(32, '0);
        dm_req_ready = 1'b1;
        repeat (20) @(negedge clk);

        expect_scan("ir_out_dmi2", 40'h1);
        scan_ir(5'h11);
        dm_req_ready = 1'b0;
        expect_scan("dmi_wr3_cap", {6'h05, 32'h00000c82, 2'b00});
        scan_dr(40, {6'h07, 32'ha5a5a5a5, 2'b10});
        tclk(1'b1, 1'b0, o);
        tclk(1'b0, 1'b0, o);
        tclk(1'b0, 1'b0, o);
        for (int i = 0; i < 3; i++) tclk(1'b0, 1'b1, o);
        repeat (4) @(negedge clk);
        expect_pins("pre_reset", 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        expect_pins("mid_reset", 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        dm_req_ready = 1'b1;
        inject_req++;
        repeat (6) @(negedge clk);

        tclk(1'b0, 1'b0, o);
        expect_scan("idcode_after_rst", {8'h0, IDC});
        scan_dr(32, '0);
        expect_scan("ir_out_after_rst", 40'h1);
        scan_ir(5'h11);
        expect_scan("dmi_after_rst", 40'h0);
        scan_dr(40, '0);
        repeat (20) @(negedge clk);

        final_req = 1'b1;
        for (int i = 0; i < 100 && !final_done; i++) @(negedge clk);
        if (!final_done) begin
            $display("FAIL final_handshake: got no completion expected monitor done");
            $fatal(1, "monitor stalled");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/jtag_dtm_oversampled.md
Name: jtag_dtm_oversampled

Overview:
- JTAG Debug Transport Module implemented as the target (TAP) end of the host sequence that drives TCK/TMS/TDI and samples TDO.
- Runs entirely in the system clock domain. TCK, TMS and TDI are oversampled, and the TAP state machine advances on detected TCK edges.
- Exposes RISC-V DTM registers IDCODE, DTMCS, DMI and BYPASS.
- Converts DMI accesses into a valid/ready request and response exchange with the debug module (DM).

Parameters:
- IDCODE_VAL, 32'h1e200a6d, value captured in IDCODE.
- ABITS, 6, DMI address width. The DMI scan register is ABITS+34 bits wide (40 at default).
- SYNC_STAGES, 2, synchroniser flops on tck, tms and tdi. Minimum 2.

Ports:
- clk  in  1  system clock; must be at least 8x the TCK frequency.
- rst  in  1  synchronous, active-high reset.
- jtag_tck  in  1  asynchronous JTAG clock.
- jtag_tms  in  1  test mode select.
- jtag_tdi  in  1  test data in.
- jtag_tdo  out  1  test data out.
- dm_req_valid  out  1  DMI request valid.
- dm_req_ready  in  1  DM accepts the request.
- dm_req_addr  out  ABITS  DMI address.
- dm_req_data  out  32  write data.
- dm_req_op  out  2  1 = read, 2 = write.
- dm_resp_valid  in  1  DM response strobe, one cycle.
- dm_resp_data  in  32  read data.

Behaviour:
- Synchronisation and edge detection
  - tck, tms and tdi each pass through SYNC_STAGES flops.
  - tck_rise = synced tck 0->1. tck_fall = synced tck 1->0.
  - tms and tdi are used at the synced value present on the tck_rise cycle.
- TAP state machine
  - The 16 IEEE 1149.1 states, advanced only on tck_rise.
  - Reset state is TEST_LOGIC_RESET.
  - Five consecutive TMS=1 rising edges reach TEST_LOGIC_RESET from any state.
- Instruction register
  - 5 bits, reset value 5'h01 (IDCODE). Forced to 5'h01 in TEST_LOGIC_RESET.
  - CAPTURE_IR loads 5'b00001.
  - SHIFT_IR shifts LSB first, with tdi entering the MSB.
  - UPDATE_IR copies the shift register into the IR.
- Instruction decode
  - 5'h01 IDCODE, 32 bits.
  - 5'h10 DTMCS, 32 bits: {14'b0, dmihardreset, dmireset, 1'b0, idle=3'd1, dmistat[1:0], abits=ABITS[5:0], version=4'd1}.
  - 5'h11 DMI, ABITS+34 bits.
  - Any other value selects BYPASS, 1 bit, captured as 0.
- Data register shifting
  - CAPTURE_DR loads the selected register.
  - For DMI the capture value is {last_addr, resp_data, dmistat}.
  - SHIFT_DR: shift right, tdi into bit [len-1]. The length is set by the decoded IR.
- TDO timing
  - jtag_tdo updates on tck_fall to shift_reg[0] (or ir_shift[0] in SHIFT_IR).
  - It holds its value in all other states. Reset value 0.
- UPDATE_DR with DMI selected
  - Fields: op = [1:0], data = [33:2], addr = [ABITS+33:34].
  - op 0 is a nop with no request.
  - If dmistat != 0 (sticky), the update is ignored.
  - If busy (request or response still outstanding), the update is ignored and dmistat is set to 3.
  - Otherwise, for op 1 or 2: latch addr, data and op; assert dm_req_valid the following clk cycle; set busy.
  - op 3 is treated as nop.
- DM handshake
  - dm_req_valid, dm_req_addr, dm_req_data and dm_req_op are held stable until the clk cycle where dm_req_valid && dm_req_ready. valid drops the next cycle.
  - On dm_resp_valid: a read stores dm_resp_data into resp_data; a write leaves resp_data unchanged. busy clears.
  - If dm_resp_valid arrives in the same cycle as the acceptance, it is honoured.
- UPDATE_DR with DTMCS selected
  - dmireset (bit 16) = 1 clears dmistat.
  - dmihardreset (bit 17) = 1 clears dmistat, busy and dm_req_valid, abandoning any response.
- Reset values
  - All outputs 0. resp_data 0, dmistat 0, busy 0, last_addr 0.
  - Shift registers 0. The IR synchroniser flops reset to 0.
- Reset asserted mid-scan or mid-handshake: all state returns immediately to its reset values. A DM response arriving after reset is ignored.
- Simultaneous tck_rise and dm_resp_valid: both take effect. If the TAP is in CAPTURE_DR, the capture uses the new resp_data and the cleared busy.

Decomposition:
- Shared package jtag_defs, holding:
  - TAP state encodings (4-bit localparams).
  - IR codes: IDCODE 5'h01, DTMCS 5'h10, DMI 5'h11, BYPASS 5'h1f.
  - DMI op codes: NOP 0, READ 1, WRITE 2.
  - dmistat codes: OK 0, FAILED 2, BUSY 3.
- One natural sub-module: jtag_edge_sync, the synchroniser plus rise/fall detection on tck, with tms and tdi passed through aligned.

Test Plan:
- Reset, then 8 TCK periods with TMS=1 -> TAP in TEST_LOGIC_RESET, IR = 5'h01. A following 32-bit DR scan returns 32'h1e200a6d on TDO, LSB first.
- Shift IR 5'b10001, then UPDATE_IR -> IR = 5'h11. The bits shifted out on TDO are 5'b00001.
- DMI scan {6'h10, 32'h00000001, 2'b10}, UPDATE_DR, DM ready held high -> one-cycle dm_req_valid with addr 6'h10, data 32'h1, op 2. Respond 2 cycles later -> busy clears.
- DMI read {6'h11, 32'h0, 2'b01}, DM returns 32'h00000c82 -> next DMI scan with op 0 returns [33:2] = 32'h00000c82 and [1:0] = 2'b00.
- DMI write while DM ready is held low, then a second UPDATE_DR -> dmistat = 3 and the second request is not issued. A DTMCS scan with bit 16 = 1 -> dmistat = 0.
- Assert rst mid-SHIFT_DR with dm_req_valid high -> next clk: dm_req_valid = 0, jtag_tdo = 0, TAP in TEST_LOGIC_RESET, IR = 5'h01.
